// File: rtl/press_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : press_evt_pkg
//  Purpose : Shared types and defaults for the press event arbiter. Defines
//            the event record (button index + press type) stored in the event
//            queue, the press-type encodings and the default sizing.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package press_evt_pkg;

  // Default sizing of the arbiter.
  localparam int DEF_NUM_BTN    = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width reserved for the button index inside a queued event. The top level
  // only drives and reads the low IDX_W bits, so up to 256 buttons fit.
  localparam int EVT_BTN_W = 8;

  // Press-type encodings carried in press_evt_t.is_long.
  localparam logic EVT_SHORT = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  typedef struct packed {
    logic [EVT_BTN_W-1:0] btn;
    logic                 is_long;
  } press_evt_t;

endpackage : press_evt_pkg
`default_nettype wire

// File: rtl/press_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : press_evt_fifo
//  Purpose : Synchronous show-ahead FIFO of press_evt_t. The head entry is
//            visible on rd_data whenever empty is low; pop advances it.
//  Ports   : clk_i    in   clock
//            rst_i    in   asynchronous active-high reset (empties the queue)
//            push     in   write wr_data this cycle (ignored when full)
//            wr_data  in   event to enqueue
//            pop      in   discard head this cycle (ignored when empty)
//            rd_data  out  head event (undefined content when empty)
//            full     out  count == DEPTH
//            empty    out  count == 0
//            count    out  number of stored entries
//  Rev     : 1.0  initial release
// ============================================================================
module press_evt_fifo
  import press_evt_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  press_evt_t       wr_data,
  input  logic             pop,
  output press_evt_t       rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  press_evt_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // Fullness is judged before this cycle's pop, so a full queue never
  // accepts a write even while the head is being consumed.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule : press_evt_fifo
`default_nettype wire

// File: rtl/press_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : press_event_arbiter
//  Purpose : Collects 1-cycle short/long press pulses from NUM_BTN long-press
//            detectors, serialises them round-robin into an event FIFO and
//            presents them one at a time over a valid/ready handshake. Any
//            press that is overwritten before being queued sets a sticky
//            overflow flag.
//  Ports   : clk_i           in   system clock
//            rst_i           in   asynchronous active-high reset
//            press_short_i   in   [NUM_BTN] short-press pulses, bit b = btn b
//            press_long_i    in   [NUM_BTN] long-press pulses,  bit b = btn b
//            cmd_valid_o     out  head event available
//            cmd_ready_i     in   consumer takes head event this cycle
//            cmd_btn_o       out  [IDX_W] button index of head event
//            cmd_long_o      out  1 = long press, 0 = short press
//            overflow_o      out  sticky: at least one press was lost
//            clr_overflow_i  in   clears overflow_o (a new loss wins)
//  Rev     : 1.0  initial release
// ============================================================================
module press_event_arbiter
  import press_evt_pkg::*;
#(
  parameter  int NUM_BTN    = DEF_NUM_BTN,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int IDX_W      = $clog2(NUM_BTN),
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] press_short_i,
  input  logic [NUM_BTN-1:0] press_long_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [IDX_W-1:0]   cmd_btn_o,
  output logic               cmd_long_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] pend_v;
  logic [NUM_BTN-1:0] pend_long;
  logic [NUM_BTN-1:0] granted;
  logic [NUM_BTN-1:0] lost;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               grant_valid;
  int                 cand;

  logic               overflow;

  press_evt_t         push_evt;
  press_evt_t         head_evt;
  logic               fifo_empty;
  logic               fifo_room;
  logic               pop;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_fifo_full;

  // A pulse of either kind makes the button pending; long wins a tie.
  assign pulse = press_short_i | press_long_i;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first pending button at or after rr_ptr, wrapping
  // modulo NUM_BTN. No grant at all while the queue is full, so neither the
  // pending flags nor rr_ptr move in that case.
  // --------------------------------------------------------------------------
  assign fifo_room = (fifo_count < CNT_W'(FIFO_DEPTH));

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (fifo_room) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cand = int'(rr_ptr) + i;
        if (cand >= NUM_BTN) cand = cand - NUM_BTN;
        cand_idx = IDX_W'(cand);
        if (!grant_valid && pend_v[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  assign rr_next = (grant_idx == IDX_W'(NUM_BTN - 1)) ? '0 : grant_idx + 1'b1;

  // A pulse is only lost when it lands on a pending button that is not
  // leaving the capture stage this very cycle.
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    assign granted[b] = grant_valid && (grant_idx == IDX_W'(b));
    assign lost[b]    = pulse[b] & pend_v[b] & ~granted[b];
  end

  // --------------------------------------------------------------------------
  // Capture flags, round-robin pointer and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v    <= '0;
      pend_long <= '0;
      rr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        // A new pulse beats the grant-clear: the granted copy is already
        // on its way into the queue, the new press stays pending.
        if (pulse[b]) begin
          pend_v[b]    <= 1'b1;
          pend_long[b] <= press_long_i[b];
        end else if (granted[b]) begin
          pend_v[b]    <= 1'b0;
        end
      end

      if (grant_valid) rr_ptr <= rr_next;

      if (|lost)               overflow <= 1'b1;
      else if (clr_overflow_i) overflow <= 1'b0;
    end
  end

  assign overflow_o = overflow;

  // --------------------------------------------------------------------------
  // Event queue
  // --------------------------------------------------------------------------
  always_comb begin
    push_evt         = '0;
    push_evt.btn     = EVT_BTN_W'(grant_idx);
    push_evt.is_long = pend_long[grant_idx] ? EVT_LONG : EVT_SHORT;
  end

  press_evt_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (grant_valid),
    .wr_data (push_evt),
    .pop     (pop),
    .rd_data (head_evt),
    .full    (unused_fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Consumer handshake; head fields read as zero while nothing is queued.
  // --------------------------------------------------------------------------
  assign cmd_valid_o = !fifo_empty;
  assign pop         = cmd_valid_o && cmd_ready_i;
  assign cmd_btn_o   = cmd_valid_o ? head_evt.btn[IDX_W-1:0] : '0;
  assign cmd_long_o  = cmd_valid_o && head_evt.is_long;

  // Index bits above IDX_W are always written as zero and never read.
  if (IDX_W < EVT_BTN_W) begin : g_btn_hi
    logic unused_btn_hi;
    assign unused_btn_hi = ^head_evt.btn[EVT_BTN_W-1:IDX_W];
  end

endmodule : press_event_arbiter
`default_nettype wire

// File: tb/tb_press_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_press_event_arbiter
//  Purpose : Self-checking bench for press_event_arbiter: directed scenarios
//            plus randomized traffic compared against a queue-based model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_press_event_arbiter;

  localparam int NUM_BTN    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = $clog2(NUM_BTN);

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NUM_BTN-1:0] press_short_i = '0;
  logic [NUM_BTN-1:0] press_long_i  = '0;
  logic               cmd_valid_o;
  logic               cmd_ready_i   = 1'b0;
  logic [IDX_W-1:0]   cmd_btn_o;
  logic               cmd_long_o;
  logic               overflow_o;
  logic               clr_overflow_i = 1'b0;

  always #5 clk_i = ~clk_i;

  press_event_arbiter #(
    .NUM_BTN        (NUM_BTN),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .press_short_i  (press_short_i),
    .press_long_i   (press_long_i),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_ready_i    (cmd_ready_i),
    .cmd_btn_o      (cmd_btn_o),
    .cmd_long_o     (cmd_long_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int btn;
    bit lng;
  } ev_t;

  // Reference model: pending press per button, ordered event queue.
  ev_t mq[$];
  ev_t got[$];
  bit  m_pv[NUM_BTN];
  bit  m_pl[NUM_BTN];
  int  m_rr;
  bit  m_ovf;

  task automatic model_reset();
    mq.delete();
    for (int b = 0; b < NUM_BTN; b++) begin
      m_pv[b] = 1'b0;
      m_pl[b] = 1'b0;
    end
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the rules: queue room is judged before the pop.
  task automatic model_step(input logic [NUM_BTN-1:0] s, input logic [NUM_BTN-1:0] l,
                            input logic rdy, input logic clr);
    int  g;
    int  c;
    bit  loss;
    ev_t e;
    g    = -1;
    loss = 1'b0;
    if (mq.size() < FIFO_DEPTH) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        c = (m_rr + i) % NUM_BTN;
        if (g < 0 && m_pv[c]) g = c;
      end
    end
    if (mq.size() != 0 && rdy) mq.delete(0);
    if (g >= 0) begin
      e.btn = g;
      e.lng = m_pl[g];
      mq.push_back(e);
      m_pv[g] = 1'b0;
      m_rr    = (g + 1) % NUM_BTN;
    end
    for (int b = 0; b < NUM_BTN; b++) begin
      if (s[b] || l[b]) begin
        if (m_pv[b]) loss = 1'b1;
        m_pv[b] = 1'b1;
        m_pl[b] = l[b];
      end
    end
    if (loss)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, record any accepted event, advance the model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic tick(input logic [NUM_BTN-1:0] s, input logic [NUM_BTN-1:0] l,
                      input logic rdy, input logic clr);
    ev_t e;
    press_short_i  = s;
    press_long_i   = l;
    cmd_ready_i    = rdy;
    clr_overflow_i = clr;
    #4;
    if (cmd_valid_o && cmd_ready_i) begin
      e.btn = int'(cmd_btn_o);
      e.lng = cmd_long_o;
      got.push_back(e);
    end
    @(posedge clk_i);
    model_step(s, l, rdy, clr);
    #1;
    press_short_i  = '0;
    press_long_i   = '0;
    clr_overflow_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid_o); end
    checks++; if (cmd_btn_o !== '0)     begin failures++; $display("FAIL reset_btn got=%0d exp=0", cmd_btn_o); end
    checks++; if (cmd_long_o !== 1'b0)  begin failures++; $display("FAIL reset_long got=%b exp=0", cmd_long_o); end
    checks++; if (overflow_o !== 1'b0)  begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single_short();
    got.delete();
    tick(2'b10, 2'b00, 1'b1, 1'b0);
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL single_t1_valid got=%b exp=0", cmd_valid_o); end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (cmd_valid_o !== 1'b1) begin failures++; $display("FAIL single_t2_valid got=%b exp=1", cmd_valid_o); end
    checks++; if (cmd_btn_o !== 1'b1)   begin failures++; $display("FAIL single_t2_btn got=%0d exp=1", cmd_btn_o); end
    checks++; if (cmd_long_o !== 1'b0)  begin failures++; $display("FAIL single_t2_long got=%b exp=0", cmd_long_o); end
    tick('0, '0, 1'b1, 1'b0);
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL single_t3_valid got=%b exp=0", cmd_valid_o); end
    checks++; if (got.size() != 1)      begin failures++; $display("FAIL single_count got=%0d exp=1", got.size()); end
  endtask

  task automatic test_simultaneous();
    for (int rep = 0; rep < 2; rep++) begin
      got.delete();
      tick(2'b01, 2'b10, 1'b1, 1'b0);
      repeat (5) tick('0, '0, 1'b1, 1'b0);
      checks++;
      if (got.size() != 2) begin
        failures++; $display("FAIL simul_count rep=%0d got=%0d exp=2", rep, got.size());
      end else begin
        checks++;
        if (got[0].btn != 0 || got[0].lng != 1'b0 || got[1].btn != 1 || got[1].lng != 1'b1) begin
          failures++;
          $display("FAIL simul_order rep=%0d got={%0d,%0d},{%0d,%0d} exp={0,0},{1,1}",
                   rep, got[0].btn, got[0].lng, got[1].btn, got[1].lng);
        end
      end
    end
  endtask

  task automatic test_fill_overflow();
    int e_btn [6];
    bit e_lng [6];
    logic [NUM_BTN-1:0] ps [6];
    logic [NUM_BTN-1:0] pl [6];
    e_btn = '{0, 1, 0, 1, 0, 1};
    e_lng = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ps    = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    pl    = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
    got.delete();
    for (int i = 0; i < 6; i++) begin
      tick(ps[i], pl[i], 1'b0, 1'b0);
      tick('0, '0, 1'b0, 1'b0);
    end
    checks++; if (cmd_valid_o !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", cmd_valid_o); end
    checks++; if (cmd_btn_o !== 1'b0)   begin failures++; $display("FAIL fill_head_btn got=%0d exp=0", cmd_btn_o); end
    checks++; if (overflow_o !== 1'b0)  begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", overflow_o); end
    tick(2'b10, 2'b00, 1'b0, 1'b0);
    checks++; if (overflow_o !== 1'b1)  begin failures++; $display("FAIL fill_ovf got=%b exp=1", overflow_o); end
    repeat (14) tick('0, '0, 1'b1, 1'b0);
    checks++;
    if (got.size() != 6) begin
      failures++; $display("FAIL drain_count got=%0d exp=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i].btn != e_btn[i] || got[i].lng != e_lng[i]) begin
          failures++;
          $display("FAIL drain_ev%0d got={%0d,%0d} exp={%0d,%0d}", i, got[i].btn, got[i].lng, e_btn[i], e_lng[i]);
        end
      end
    end
  endtask

  task automatic test_short_long_tie();
    got.delete();
    tick(2'b01, 2'b01, 1'b1, 1'b0);
    repeat (4) tick('0, '0, 1'b1, 1'b0);
    checks++;
    if (got.size() != 1) begin
      failures++; $display("FAIL tie_count got=%0d exp=1", got.size());
    end else begin
      checks++;
      if (got[0].btn != 0 || got[0].lng != 1'b1) begin
        failures++; $display("FAIL tie_event got={%0d,%0d} exp={0,1}", got[0].btn, got[0].lng);
      end
    end
  endtask

  task automatic test_clr_overflow();
    tick('0, '0, 1'b1, 1'b1);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", overflow_o); end
    tick('0, '0, 1'b1, 1'b1);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL clr_noloss got=%b exp=0", overflow_o); end
    tick(2'b11, '0, 1'b1, 1'b0);
    tick(2'b11, '0, 1'b1, 1'b1);
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL clr_vs_loss got=%b exp=1", overflow_o); end
    repeat (6) tick('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    tick(2'b00, 2'b10, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    tick(2'b01, 2'b00, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    tick(2'b10, 2'b00, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    tick(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_btn_o !== 1'b1 || cmd_long_o !== 1'b1 || overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL prerst_state got v=%b b=%0d l=%b o=%b exp v=1 b=1 l=1 o=1",
               cmd_valid_o, cmd_btn_o, cmd_long_o, overflow_o);
    end
    #1 rst_i = 1'b1;
    model_reset();
    #1;
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", cmd_valid_o); end
    checks++; if (cmd_btn_o !== '0)     begin failures++; $display("FAIL midrst_btn got=%0d exp=0", cmd_btn_o); end
    checks++; if (cmd_long_o !== 1'b0)  begin failures++; $display("FAIL midrst_long got=%b exp=0", cmd_long_o); end
    checks++; if (overflow_o !== 1'b0)  begin failures++; $display("FAIL midrst_ovf got=%b exp=0", overflow_o); end
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick('0, '0, 1'b1, 1'b0);
      checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL postrst_stale%0d got=%b exp=0", i, cmd_valid_o); end
    end
    tick(2'b01, 2'b00, 1'b1, 1'b0);
    checks++; if (cmd_valid_o !== 1'b0) begin failures++; $display("FAIL postrst_t1 got=%b exp=0", cmd_valid_o); end
    tick('0, '0, 1'b1, 1'b0);
    checks++;
    if (cmd_valid_o !== 1'b1 || cmd_btn_o !== 1'b0 || cmd_long_o !== 1'b0) begin
      failures++;
      $display("FAIL postrst_t2 got v=%b b=%0d l=%b exp v=1 b=0 l=0", cmd_valid_o, cmd_btn_o, cmd_long_o);
    end
    repeat (2) tick('0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [NUM_BTN-1:0] s;
    logic [NUM_BTN-1:0] l;
    logic               rdy;
    logic               clr;
    logic               e_valid;
    logic [IDX_W-1:0]   e_btn;
    logic               e_long;
    int                 rdy_pct;
    int                 err_here;
    rdy_pct = 50;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 100 == 0) rdy_pct = (cyc % 200 == 0) ? 20 : 90;
      s   = ($urandom_range(0, 2) == 0) ? NUM_BTN'($urandom) : '0;
      l   = ($urandom_range(0, 3) == 0) ? NUM_BTN'($urandom) : '0;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      clr = ($urandom_range(0, 15) == 0);
      tick(s, l, rdy, clr);
      e_valid = (mq.size() != 0);
      e_btn   = e_valid ? IDX_W'(mq[0].btn) : '0;
      e_long  = e_valid ? mq[0].lng : 1'b0;
      err_here = 0;
      checks++;
      if (cmd_valid_o !== e_valid) begin
        failures++; err_here++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, cmd_valid_o, e_valid);
      end
      checks++;
      if (cmd_btn_o !== e_btn || cmd_long_o !== e_long) begin
        failures++; err_here++;
        $display("FAIL rand_head cyc=%0d got={%0d,%b} exp={%0d,%b}", cyc, cmd_btn_o, cmd_long_o, e_btn, e_long);
      end
      checks++;
      if (overflow_o !== m_ovf) begin
        failures++; err_here++;
        $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow_o, m_ovf);
      end
      if (err_here != 0 && failures > 20) break;
    end
    got.delete();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_short();
    test_simultaneous();
    test_fill_overflow();
    test_short_long_tie();
    test_clr_overflow();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_press_event_arbiter
`default_nettype wire
